elevator_controller: RTL

Car controller FSM for the elevator plant. Latches floor-call buttons, schedules travel with SCAN ordering (keep direction while calls remain ahead), and drives the 2-bit engine and door command buses. Consumes the plant's floor-pass pulses and door-position sensor. Includes a sensor watchdog that parks the car in a latched fault state.

---
 rtl/elevator_pkg.sv | 43 ++++
 rtl/elevator_controller_if.sv | 32 +++
 rtl/elevator_req_sched.sv | 24 ++
 rtl/elevator_controller.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared encodings and the car FSM state type for the elevator controller slice.
package elevator_pkg;

  localparam logic [1:0] ENG_IDLE = 2'd0;
  localparam logic [1:0] ENG_DOWN = 2'd1;
  localparam logic [1:0] ENG_UP   = 2'd2;

  localparam logic [1:0] DOOR_CMD_IDLE  = 2'd0;
  localparam logic [1:0] DOOR_CMD_OPEN  = 2'd1;
  localparam logic [1:0] DOOR_CMD_CLOSE = 2'd2;

  localparam logic [1:0] SDOOR_BETWEEN = 2'd0;
  localparam logic [1:0] SDOOR_OPEN    = 2'd1;
  localparam logic [1:0] SDOOR_CLOSED  = 2'd2;

  typedef enum logic [2:0] {
    IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, DWELL, DOOR_CLOSE, FAULT
  } state_t;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  // States in which the plant owes us a sensor event within the timeout.
  function automatic logic watched(state_t s);
    return (s == MOVE_UP) || (s == MOVE_DOWN) || (s == DOOR_OPEN) || (s == DOOR_CLOSE);
  endfunction

  function automatic logic [1:0] engine_of(state_t s);
    case (s)
      MOVE_UP:   return ENG_UP;
      MOVE_DOWN: return ENG_DOWN;
      default:   return ENG_IDLE;
    endcase
  endfunction

  function automatic logic [1:0] door_of(state_t s);
    case (s)
      DOOR_OPEN:  return DOOR_CMD_OPEN;
      DOOR_CLOSE: return DOOR_CMD_CLOSE;
      default:    return DOOR_CMD_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/elevator_controller_if.sv
// Bus between the car controller and the plant/call panel.
interface elevator_controller_if #(
  parameter int BUTTONS_WIDTH = 8,
  parameter int FLOOR_W       = $clog2(BUTTONS_WIDTH)
);
  import elevator_pkg::*;

  // No valid/ready here: buttons are levels sampled every cycle, sensor_up/down
  // are single-cycle pulses, sensor_door is a level; commands are registered levels.
  logic [BUTTONS_WIDTH-1:0] buttons;
  logic [1:0]               sensor_door;
  logic                     sensor_up;
  logic                     sensor_down;
  logic [1:0]               engine;
  logic [1:0]               door;
  logic [FLOOR_W-1:0]       floor;
  logic [BUTTONS_WIDTH-1:0] pending;
  logic                     busy;
  logic                     fault;
  state_t                   state;

  modport master (
    output buttons, sensor_door, sensor_up, sensor_down,
    input  engine, door, floor, pending, busy, fault, state
  );

  modport slave (
    input  buttons, sensor_door, sensor_up, sensor_down,
    output engine, door, floor, pending, busy, fault, state
  );

endinterface

// File: rtl/elevator_req_sched.sv
// SCAN helper: reports whether calls are pending above, below or at the current floor.
module elevator_req_sched #(
  parameter int BUTTONS_WIDTH = 8,
  parameter int FLOOR_W       = $clog2(BUTTONS_WIDTH)
) (
  input  logic [BUTTONS_WIDTH-1:0] pending,
  input  logic [FLOOR_W-1:0]       floor,
  output logic                     any_above,
  output logic                     any_below,
  output logic                     here
);

  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    for (int i = 0; i < BUTTONS_WIDTH; i++) begin
      if ((i > int'(floor)) && pending[i]) any_above = 1'b1;
      if ((i < int'(floor)) && pending[i]) any_below = 1'b1;
    end
  end

  assign here = pending[floor];

endmodule

// File: rtl/elevator_controller.sv
// Elevator car FSM: latches calls, serves them in SCAN order, sequences the door,
// and parks in a sticky FAULT when a sensor event does not arrive in time.
module elevator_controller
  import elevator_pkg::*;
#(
  parameter int BUTTONS_WIDTH = 8,
  parameter int FLOOR_W       = $clog2(BUTTONS_WIDTH),
  parameter int DOOR_DWELL    = 20,
  parameter int TIMEOUT       = 64
) (
  input  logic                  clock,
  input  logic                  an_reset,
  elevator_controller_if.slave  bus
);

  localparam int                 DW_W = $clog2(DOOR_DWELL + 1);
  localparam int                 WD_W = $clog2(TIMEOUT + 1);
  localparam logic [FLOOR_W-1:0] TOP  = FLOOR_W'(BUTTONS_WIDTH - 1);

  state_t                   state, next_state;
  dir_t                     dir_q, dir_next;
  logic [FLOOR_W-1:0]       floor_q, floor_next, floor_up, floor_dn;
  logic [BUTTONS_WIDTH-1:0] pending_q, pending_next, accept, pend_now, clear_mask;
  logic [DW_W-1:0]          dwell_q, dwell_next;
  logic [WD_W-1:0]          wd_q, wd_next;
  logic [1:0]               engine_q, door_q;
  logic                     busy_q, fault_q;
  logic                     any_above, any_below, here;
  logic                     cur_btn, pulse_ok, clear_cur;

  elevator_req_sched #(
    .BUTTONS_WIDTH (BUTTONS_WIDTH),
    .FLOOR_W       (FLOOR_W)
  ) u_sched (
    .pending   (pending_q),
    .floor     (floor_q),
    .any_above (any_above),
    .any_below (any_below),
    .here      (here)
  );

  assign floor_up = floor_q + 1'b1;
  assign floor_dn = floor_q - 1'b1;
  assign cur_btn  = bus.buttons[floor_q];

  always_comb begin
    next_state = state;
    dir_next   = dir_q;
    floor_next = floor_q;
    dwell_next = dwell_q;
    pulse_ok   = 1'b0;
    clear_cur  = 1'b0;
    accept     = bus.buttons;
    clear_mask = '0;

    // With the door at this floor, its button is a "hold the door" request, not a call.
    case (state)
      DWELL, DOOR_CLOSE: accept[floor_q] = 1'b0;
      FAULT:             accept = '0;
      default:           ;
    endcase
    pend_now = pending_q | accept;

    case (state)
      IDLE: begin
        if (here) begin
          next_state = DOOR_OPEN;
        end else if (any_above && ((dir_q == DIR_UP) || !any_below)) begin
          dir_next   = DIR_UP;
          next_state = MOVE_UP;
        end else if (any_below) begin
          dir_next   = DIR_DOWN;
          next_state = MOVE_DOWN;
        end
      end
      MOVE_UP: begin
        if (bus.sensor_up) begin
          if (floor_q == TOP) begin
            next_state = IDLE;
          end else begin
            pulse_ok   = 1'b1;
            floor_next = floor_up;
            if (pend_now[floor_up]) next_state = DOOR_OPEN;
          end
        end
      end
      MOVE_DOWN: begin
        if (bus.sensor_down) begin
          if (floor_q == '0) begin
            next_state = IDLE;
          end else begin
            pulse_ok   = 1'b1;
            floor_next = floor_dn;
            if (pend_now[floor_dn]) next_state = DOOR_OPEN;
          end
        end
      end
      DOOR_OPEN: begin
        if (bus.sensor_door == SDOOR_OPEN) begin
          clear_cur  = 1'b1;
          dwell_next = '0;
          next_state = DWELL;
        end
      end
      DWELL: begin
        if (cur_btn) begin
          dwell_next = '0;
        end else if (dwell_q == DW_W'(DOOR_DWELL - 1)) begin
          next_state = DOOR_CLOSE;
        end else begin
          dwell_next = dwell_q + 1'b1;
        end
      end
      DOOR_CLOSE: begin
        if (cur_btn) begin
          next_state = DOOR_OPEN;
        end else if (bus.sensor_door == SDOOR_CLOSED) begin
          next_state = IDLE;
        end
      end
      default: ;
    endcase

    if (watched(state) && (next_state == state) && !pulse_ok && (wd_q == WD_W'(TIMEOUT - 1))) begin
      next_state = FAULT;
    end

    if ((next_state != state) || pulse_ok || !watched(state)) wd_next = '0;
    else                                                      wd_next = wd_q + 1'b1;

    if (clear_cur) clear_mask[floor_q] = 1'b1;
    pending_next = pend_now & ~clear_mask;
  end

  always_ff @(posedge clock or negedge an_reset) begin
    if (!an_reset) begin
      state     <= IDLE;
      dir_q     <= DIR_UP;
      floor_q   <= '0;
      pending_q <= '0;
      dwell_q   <= '0;
      wd_q      <= '0;
      engine_q  <= ENG_IDLE;
      door_q    <= DOOR_CMD_IDLE;
      busy_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state     <= next_state;
      dir_q     <= dir_next;
      floor_q   <= floor_next;
      pending_q <= pending_next;
      dwell_q   <= dwell_next;
      wd_q      <= wd_next;
      engine_q  <= engine_of(next_state);
      door_q    <= door_of(next_state);
      busy_q    <= (next_state != IDLE);
      fault_q   <= (next_state == FAULT);
    end
  end

  assign bus.engine  = engine_q;
  assign bus.door    = door_q;
  assign bus.floor   = floor_q;
  assign bus.pending = pending_q;
  assign bus.busy    = busy_q;
  assign bus.fault   = fault_q;
  assign bus.state   = state;

endmodule
